// File: rtl/lsu_mem_stage.sv
// Memory-access stage: turns EX bundles into req/gnt/rvalid data-bus
// transactions and emits a registered writeback bundle.
// Optional build macro: LSU_MISALIGN_TRAP_EN (misaligned accesses are trapped
// without a bus request and flagged on misalign_o).
module lsu_mem_stage #(
    parameter int unsigned    XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic            wmem_en_i,
    input  logic            rmem_en_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic            wreg_en_i,
    input  logic [4:0]      wreg_addr_i,
    input  logic [XLEN-1:0] wreg_data_i,
    output logic            dbus_req_o,
    output logic            dbus_we_o,
    output logic [XLEN-1:0] dbus_addr_o,
    output logic [3:0]      dbus_be_o,
    output logic [XLEN-1:0] dbus_wdata_o,
    input  logic            dbus_gnt_i,
    input  logic            dbus_rvalid_i,
    input  logic [XLEN-1:0] dbus_rdata_i,
    output logic            valid_o,
    output logic            wreg_en_o,
    output logic [4:0]      wreg_addr_o,
    output logic [XLEN-1:0] wreg_data_o
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic            misalign_o
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e            state_q, state_d;
    logic              is_load_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic              wen_q;
    logic [4:0]        waddr_q;

    logic              accept_c, mem_op_c, misalign_c;
    logic              ready_d, req_d, we_d, valid_d, wen_o_d;
    logic [XLEN-1:0]   addr_d, wdata_d, wdata_o_d;
    logic [3:0]        be_d;
    logic [4:0]        waddr_o_d;
    logic              misalign_d;

    // Select the addressed byte/half lane of a read word and extend it.
    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] w,
                                                     input logic [1:0] off,
                                                     input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> {off, 3'b000});
        h = 16'(w >> {off[1], 4'b0000});
        case (f3[1:0])
            2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // Misalignment detection only exists in the trapping build.
    always_comb begin
        misalign_c = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        case (funct3_i[1:0])
            2'b00:   misalign_c = 1'b0;
            2'b01:   misalign_c = mem_addr_i[0];
            default: misalign_c = (mem_addr_i[1:0] != 2'b00);
        endcase
`endif
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        req_d      = 1'b0;
        we_d       = dbus_we_o;
        addr_d     = dbus_addr_o;
        be_d       = dbus_be_o;
        wdata_d    = dbus_wdata_o;
        valid_d    = 1'b0;
        wen_o_d    = 1'b0;
        waddr_o_d  = wreg_addr_o;
        wdata_o_d  = wreg_data_o;
        misalign_d = 1'b0;
        accept_c   = valid_i & ready_o;
        mem_op_c   = wmem_en_i | rmem_en_i;

        case (state_q)
            IDLE: begin
                if (accept_c && mem_op_c && misalign_c) begin
                    valid_d    = 1'b1;
                    waddr_o_d  = wreg_addr_i;
                    misalign_d = 1'b1;
                end else if (accept_c && mem_op_c) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    we_d    = wmem_en_i;
                    addr_d  = {mem_addr_i[XLEN-1:2], 2'b00};
                    if (wmem_en_i) begin
                        case (funct3_i[1:0])
                            2'b00: begin
                                be_d    = 4'b0001 << mem_addr_i[1:0];
                                wdata_d = {4{store_data_i[7:0]}};
                            end
                            2'b01: begin
                                be_d    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                                wdata_d = {2{store_data_i[15:0]}};
                            end
                            default: begin
                                be_d    = 4'b1111;
                                wdata_d = store_data_i;
                            end
                        endcase
                    end else begin
                        be_d    = 4'b1111;
                        wdata_d = '0;
                    end
                end else if (accept_c) begin
                    valid_d   = 1'b1;
                    wen_o_d   = wreg_en_i;
                    waddr_o_d = wreg_addr_i;
                    wdata_o_d = wreg_data_i;
                end
            end
            REQ: begin
                req_d = 1'b1;
                if (dbus_gnt_i) begin
                    req_d = 1'b0;
                    if (is_load_q) begin
                        state_d = RESP;
                    end else begin
                        state_d   = IDLE;
                        valid_d   = 1'b1;
                        waddr_o_d = waddr_q;
                        we_d      = 1'b0;
                        addr_d    = RESET_ADDR;
                        be_d      = 4'b0000;
                        wdata_d   = '0;
                    end
                end
            end
            RESP: begin
                if (dbus_rvalid_i) begin
                    state_d   = IDLE;
                    valid_d   = 1'b1;
                    wen_o_d   = wen_q;
                    waddr_o_d = waddr_q;
                    wdata_o_d = load_extract(dbus_rdata_i, off_q, f3_q);
                    we_d      = 1'b0;
                    addr_d    = RESET_ADDR;
                    be_d      = 4'b0000;
                    wdata_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_o      <= 1'b1;
            dbus_req_o   <= 1'b0;
            dbus_we_o    <= 1'b0;
            dbus_addr_o  <= RESET_ADDR;
            dbus_be_o    <= 4'b0000;
            dbus_wdata_o <= '0;
            valid_o      <= 1'b0;
            wreg_en_o    <= 1'b0;
            wreg_addr_o  <= 5'd0;
            wreg_data_o  <= '0;
        end else begin
            state_q      <= state_d;
            ready_o      <= ready_d;
            dbus_req_o   <= req_d;
            dbus_we_o    <= we_d;
            dbus_addr_o  <= addr_d;
            dbus_be_o    <= be_d;
            dbus_wdata_o <= wdata_d;
            valid_o      <= valid_d;
            wreg_en_o    <= wen_o_d;
            wreg_addr_o  <= waddr_o_d;
            wreg_data_o  <= wdata_o_d;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // One-cycle misalignment flag.
    always_ff @(posedge clk) begin
        if (rst) misalign_o <= 1'b0;
        else     misalign_o <= misalign_d;
    end
`endif

    // Bundle fields needed to finish a memory op after it leaves EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_load_q <= 1'b0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            wen_q     <= 1'b0;
            waddr_q   <= 5'd0;
        end else if (state_q == IDLE && accept_c && mem_op_c) begin
            is_load_q <= ~wmem_en_i;
            f3_q      <= funct3_i;
            off_q     <= mem_addr_i[1:0];
            wen_q     <= wreg_en_i;
            waddr_q   <= wreg_addr_i;
        end
    end

endmodule
